// File: rtl/tl_adapter_bram_pipe_pkg.sv
// Shared TL-UL definitions for the BRAM pipeline adapter: opcode encodings,
// default channel field widths and small opcode helpers.
package tl_adapter_bram_pipe_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      ArithmeticData = 3'h2,
      LogicalData    = 3'h3,
      Get            = 3'h4,
      Intent         = 3'h5
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   localparam int TlAddrWidth   = 32;
   localparam int TlSourceWidth = 8;
   localparam int TlSizeWidth   = 2;
   localparam int TlSinkWidth   = 1;

   // Only Get carries data back; everything else is acknowledged without data.
   function automatic logic [2:0] tl_resp_opcode(input logic [2:0] a_op);
      return (a_op == Get) ? 3'(AccessAckData) : 3'(AccessAck);
   endfunction

   function automatic logic tl_op_supported(input logic [2:0] a_op);
      return (a_op == Get) || (a_op == PutFullData) || (a_op == PutPartialData);
   endfunction

endpackage

// File: rtl/tl_adapter_bram_fifo.sv
// Synchronous FIFO with modulo-Depth pointers (any Depth >= 1). A push while
// full is accepted only if a pop frees the head slot in the same cycle.
// Storage is not reset; only pointers and occupancy are.
module tl_adapter_bram_fifo #(
   parameter int Width = 8,
   parameter int Depth = 2
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [Width-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [Width-1:0]           rdata_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(Depth+1)-1:0] count_o
);

   localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int CntW = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, rptr_q;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             push_ok, pop_ok;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
   endfunction

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CntW'(Depth));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[rptr_q];
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   // Occupancy next state
   always_comb begin
      cnt_d = cnt_q;
      case ({push_ok, pop_ok})
         2'b10:   cnt_d = cnt_q + CntW'(1);
         2'b01:   cnt_d = cnt_q - CntW'(1);
         default: ;
      endcase
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) wptr_q <= ptr_inc(wptr_q);
         if (pop_ok)  rptr_q <= ptr_inc(rptr_q);
         cnt_q <= cnt_d;
      end
   end

   // Payload storage, deliberately unreset
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/tl_adapter_bram_pipe.sv
// TL-UL device adapter in front of a synchronous BRAM with BramLatency cycles
// of read latency. Credits cover pipeline + response FIFO so a read result
// always has a slot, whatever the D-channel backpressure.
// Optional feature macro: TL_ADAPTER_BRAM_PIPE_ERR_EN enables denial of
// out-of-range addresses and unsupported opcodes.
module tl_adapter_bram_pipe
   import tl_adapter_bram_pipe_pkg::*;
#(
   parameter int DataWidth     = 64,
   parameter int BramAddrWidth = 12,
   parameter int BramDepth     = 2**BramAddrWidth,
   parameter int BramLatency   = 1,
   parameter int FifoDepth     = BramLatency + 1,
   parameter int AddrWidth     = TlAddrWidth,
   parameter int SourceWidth   = TlSourceWidth,
   parameter int SizeWidth     = TlSizeWidth,
   parameter int SinkWidth     = TlSinkWidth
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   // A channel
   input  logic                     a_valid_i,
   output logic                     a_ready_o,
   input  logic [2:0]               a_opcode_i,
   input  logic [2:0]               a_param_i,
   input  logic [SizeWidth-1:0]     a_size_i,
   input  logic [SourceWidth-1:0]   a_source_i,
   input  logic [AddrWidth-1:0]     a_address_i,
   input  logic [DataWidth/8-1:0]   a_mask_i,
   input  logic [DataWidth-1:0]     a_data_i,
   // D channel
   output logic                     d_valid_o,
   input  logic                     d_ready_i,
   output logic [2:0]               d_opcode_o,
   output logic [2:0]               d_param_o,
   output logic [SizeWidth-1:0]     d_size_o,
   output logic [SinkWidth-1:0]     d_sink_o,
   output logic [SourceWidth-1:0]   d_source_o,
   output logic [DataWidth-1:0]     d_data_o,
   output logic                     d_denied_o,
   output logic                     d_corrupt_o,
   // BRAM
   output logic                     bram_en_o,
   output logic                     bram_we_o,
   output logic [BramAddrWidth-1:0] bram_addr_o,
   output logic [DataWidth/8-1:0]   bram_wmask_o,
   output logic [DataWidth-1:0]     bram_wdata_o,
   input  logic [DataWidth-1:0]     bram_rdata_i
);

   localparam int MaskWidth = DataWidth / 8;
   localparam int OffWidth  = $clog2(MaskWidth);
   localparam int CntWidth  = $clog2(FifoDepth + 1);

   typedef struct packed {
      logic [2:0]             opcode;
      logic [SizeWidth-1:0]   size;
      logic [SourceWidth-1:0] source;
      logic                   denied;
   } meta_t;

   typedef struct packed {
      meta_t                  meta;
      logic [DataWidth-1:0]   data;
   } entry_t;

   logic                   do_op, pop, denied;
   logic [CntWidth-1:0]    outstanding_q, outstanding_d;
   logic [BramLatency-1:0] vld_q;
   meta_t                  meta_q [BramLatency];
   meta_t                  meta_in;
   entry_t                 push_entry, head_entry;
   logic                   fifo_empty, fifo_full;
   logic [CntWidth-1:0]    fifo_cnt;

   // Request decode and BRAM drive; only bram_en_o sees d_ready (via a_ready)
   assign pop          = d_valid_o && d_ready_i;
   assign a_ready_o    = (outstanding_q < CntWidth'(FifoDepth)) || pop;
   assign do_op        = a_valid_i && a_ready_o;
   assign bram_en_o    = do_op && !denied;
   assign bram_we_o    = (a_opcode_i == PutFullData) || (a_opcode_i == PutPartialData);
   assign bram_addr_o  = a_address_i[OffWidth +: BramAddrWidth];
   assign bram_wmask_o = a_mask_i;
   assign bram_wdata_o = a_data_i;

`ifdef TL_ADAPTER_BRAM_PIPE_ERR_EN
   localparam logic [BramAddrWidth:0] DepthLimit = (BramAddrWidth + 1)'(BramDepth);
   logic addr_upper_set, word_oob;

   if (AddrWidth > OffWidth + BramAddrWidth) begin : g_upper
      assign addr_upper_set = |a_address_i[AddrWidth-1:OffWidth+BramAddrWidth];
   end else begin : g_no_upper
      assign addr_upper_set = 1'b0;
   end

   assign word_oob = ({1'b0, bram_addr_o} >= DepthLimit);
   assign denied   = addr_upper_set || word_oob || !tl_op_supported(a_opcode_i);
`else
   assign denied = 1'b0;
`endif

   // Metadata captured at accept, travelling alongside the BRAM read
   always_comb begin
      meta_in        = '0;
      meta_in.opcode = tl_resp_opcode(a_opcode_i);
      meta_in.size   = a_size_i;
      meta_in.source = a_source_i;
      meta_in.denied = denied;
   end

   // Pipeline valid bits; cleared on reset so nothing in flight survives
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= do_op;
         for (int i = 1; i < BramLatency; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   // Pipeline metadata payload, unreset
   always_ff @(posedge clk_i) begin
      if (do_op) meta_q[0] <= meta_in;
      for (int i = 1; i < BramLatency; i++) meta_q[i] <= meta_q[i-1];
   end

   // Response entry at the last stage; denied reads return zero data
   always_comb begin
      push_entry      = '0;
      push_entry.meta = meta_q[BramLatency-1];
      push_entry.data = meta_q[BramLatency-1].denied ? '0 : bram_rdata_i;
   end

   tl_adapter_bram_fifo #(
      .Width ($bits(entry_t)),
      .Depth (FifoDepth)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (vld_q[BramLatency-1]),
      .wdata_i (push_entry),
      .pop_i   (pop),
      .rdata_o (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt)
   );

   assign d_valid_o   = !fifo_empty;
   assign d_opcode_o  = head_entry.meta.opcode;
   assign d_param_o   = '0;
   assign d_size_o    = head_entry.meta.size;
   assign d_sink_o    = '0;
   assign d_source_o  = head_entry.meta.source;
   assign d_data_o    = head_entry.data;
   assign d_denied_o  = head_entry.meta.denied;
   assign d_corrupt_o = head_entry.meta.denied && (head_entry.meta.opcode == AccessAckData);

   // Credit count next state: +1 per accept, -1 per pop
   always_comb begin
      outstanding_d = outstanding_q;
      case ({do_op, pop})
         2'b10:   outstanding_d = outstanding_q + CntWidth'(1);
         2'b01:   outstanding_d = outstanding_q - CntWidth'(1);
         default: ;
      endcase
   end

   // Credit counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) outstanding_q <= '0;
      else         outstanding_q <= outstanding_d;
   end

   // Inputs/status that carry no meaning here (byte offset, param, FIFO status)
   logic unused_sig;
   assign unused_sig = ^{a_address_i, a_param_i, fifo_full, fifo_cnt};

endmodule

// File: tb/tb_tl_adapter_bram_pipe.sv
// Randomized self-checking bench for tl_adapter_bram_pipe. The reference is a
// word-addressed shadow memory plus an in-order queue of expected responses,
// each tagged with the earliest cycle it may appear on D.
module tb_tl_adapter_bram_pipe;

   localparam int L   = 2;
   localparam int FD  = 3;
   localparam int BAW = 10;

   localparam logic [2:0] OP_PF = 3'h0, OP_PP = 3'h1, OP_GET = 3'h4;
   localparam logic [2:0] D_ACK = 3'h0, D_ACKD = 3'h1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        a_valid = 1'b0, a_ready;
   logic [2:0]  a_opcode = '0, a_param = '0;
   logic [1:0]  a_size = '0;
   logic [7:0]  a_source = '0;
   logic [31:0] a_address = '0;
   logic [7:0]  a_mask = '0;
   logic [63:0] a_data = '0;
   logic        d_valid, d_ready = 1'b0;
   logic [2:0]  d_opcode, d_param;
   logic [1:0]  d_size;
   logic [0:0]  d_sink;
   logic [7:0]  d_source;
   logic [63:0] d_data;
   logic        d_denied, d_corrupt;
   logic        bram_en, bram_we;
   logic [BAW-1:0] bram_addr;
   logic [7:0]  bram_wmask;
   logic [63:0] bram_wdata, bram_rdata;

   always #5 clk = ~clk;

   tl_adapter_bram_pipe #(
      .DataWidth(64), .BramAddrWidth(BAW), .BramLatency(L), .FifoDepth(FD)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .a_valid_i(a_valid), .a_ready_o(a_ready), .a_opcode_i(a_opcode),
      .a_param_i(a_param), .a_size_i(a_size), .a_source_i(a_source),
      .a_address_i(a_address), .a_mask_i(a_mask), .a_data_i(a_data),
      .d_valid_o(d_valid), .d_ready_i(d_ready), .d_opcode_o(d_opcode),
      .d_param_o(d_param), .d_size_o(d_size), .d_sink_o(d_sink),
      .d_source_o(d_source), .d_data_o(d_data), .d_denied_o(d_denied),
      .d_corrupt_o(d_corrupt),
      .bram_en_o(bram_en), .bram_we_o(bram_we), .bram_addr_o(bram_addr),
      .bram_wmask_o(bram_wmask), .bram_wdata_o(bram_wdata), .bram_rdata_i(bram_rdata)
   );

   // BRAM environment model: byte-masked write, L-cycle registered read
   logic [63:0] mem [0:(1<<BAW)-1];
   logic [63:0] rd_pipe [L];
   always @(posedge clk) begin
      if (bram_en) begin
         if (bram_we) begin
            for (int b = 0; b < 8; b++)
               if (bram_wmask[b]) mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
         end else begin
            rd_pipe[0] <= mem[bram_addr];
         end
      end
      for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bram_rdata = rd_pipe[L-1];

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  size;
      logic [7:0]  src;
      logic [63:0] data;
      logic        chk_data;
      logic        denied;
      logic        corrupt;
      int          rdy;
   } exp_t;

   exp_t        exp_q[$];
   logic [63:0] ref_mem [int];
   int          n_chk = 0, n_pass = 0, cyc = 0;
   logic [63:0] last_get_data;
   logic        last_denied;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic model_denied(input logic [2:0] op, input logic [31:0] addr);
`ifdef TL_ADAPTER_BRAM_PIPE_ERR_EN
      return (addr[31:13] != 0) || !(op == OP_PF || op == OP_PP || op == OP_GET);
`else
      return (op == 3'h7) && (addr == 32'hFFFF_FFFF) && 1'b0;
`endif
   endfunction

   // One cycle: drive at negedge, sample 1ns later, update the reference model
   task automatic step(input logic av, input logic [2:0] op, input logic [31:0] addr,
                       input logic [7:0] mask, input logic [63:0] data,
                       input logic [7:0] src, input logic [1:0] sz, input logic dr,
                       output logic acc);
      logic ev, ear, den, is_put;
      int   w;
      exp_t e;
      logic [63:0] cur;
      @(negedge clk);
      a_valid = av; a_opcode = op; a_address = addr; a_mask = mask;
      a_data = data; a_source = src; a_size = sz; d_ready = dr;
      #1;
      ev  = (exp_q.size() > 0) && (cyc >= exp_q[0].rdy);
      ear = (exp_q.size() < FD) || (ev && dr);
      check("d_valid", d_valid, ev);
      check("a_ready", a_ready, ear);
      w      = int'(addr[3 +: BAW]);
      den    = model_denied(op, addr);
      is_put = (op == OP_PF) || (op == OP_PP);
      acc    = av && a_ready;
      check("bram_en", bram_en, acc && !den);
      if (acc && !den) begin
         check("bram_we", bram_we, is_put);
         check("bram_addr", bram_addr, w);
      end
      if (ev && dr && d_valid) begin
         e = exp_q.pop_front();
         check("d_opcode", d_opcode, e.op);
         check("d_source", d_source, e.src);
         check("d_size", d_size, e.size);
         check("d_denied", d_denied, e.denied);
         check("d_corrupt", d_corrupt, e.corrupt);
         check("d_param", d_param, 0);
         if (e.chk_data) check("d_data", d_data, e.data);
         if (e.op == D_ACKD) last_get_data = d_data;
         last_denied = d_denied;
      end
      if (acc) begin
         e.op       = is_put ? D_ACK : D_ACKD;
         e.size     = sz;
         e.src      = src;
         e.denied   = den;
         e.corrupt  = den && !is_put;
         e.rdy      = cyc + L + 1;
         e.chk_data = 1'b0;
         e.data     = '0;
         if (!is_put) begin
            if (den) e.chk_data = 1'b1;
            else if (ref_mem.exists(w)) begin e.chk_data = 1'b1; e.data = ref_mem[w]; end
         end else if (!den) begin
            cur = ref_mem.exists(w) ? ref_mem[w] : 64'h0;
            for (int b = 0; b < 8; b++) if (mask[b]) cur[b*8 +: 8] = data[b*8 +: 8];
            ref_mem[w] = cur;
         end
         exp_q.push_back(e);
      end
      cyc++;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [7:0] mask,
                       input logic [63:0] data, input logic [7:0] src);
      logic acc = 1'b0;
      for (int n = 0; n < 20 && !acc; n++) step(1'b1, op, addr, mask, data, src, 2'd3, 1'b1, acc);
      check("send_accept", acc, 1);
   endtask

   task automatic drain();
      logic acc;
      for (int n = 0; n < 60 && exp_q.size() > 0; n++) step(1'b0, 3'h0, 0, 0, 0, 0, 2'd0, 1'b1, acc);
      check("drain_empty", exp_q.size(), 0);
   endtask

   initial begin
      logic acc;
      int   k;
      logic [31:0] addr;
      logic [2:0]  op;
      #1 rst_n = 1'b0;
      #1;
      check("rst_d_valid", d_valid, 0);
      check("rst_a_ready", a_ready, 1);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // Known contents for the eight words exercised below
      for (int w = 0; w < 8; w++) send(OP_PF, 32'(w) << 3, 8'hFF, {$urandom, $urandom}, 8'(w));

      // Put then Get, back to back
      send(OP_PF, 32'h10, 8'hFF, 64'hDEAD_BEEF, 8'h01);
      send(OP_GET, 32'h10, 8'hFF, 64'h0, 8'h02);
      drain();
      check("put_get_data", last_get_data, 64'hDEAD_BEEF);

      // Partial write merge
      send(OP_PF, 32'h18, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h03);
      send(OP_PP, 32'h18, 8'h0F, 64'h1111_1111_2222_2222, 8'h04);
      send(OP_GET, 32'h18, 8'hFF, 64'h0, 8'h05);
      drain();
      check("partial_merge", last_get_data, 64'hFFFF_FFFF_2222_2222);

      // Throughput: 20 back-to-back Gets with d_ready high
      k = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, OP_GET, 32'(i % 8) << 3, 8'hFF, 0, 8'(8'h40 + i), 2'd3, 1'b1, acc);
         if (acc) k++;
      end
      check("tput_accepts", k, 20);
      drain();

      // Backpressure: only FD requests fit while d_ready is low
      k = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, OP_GET, 32'(k % 8) << 3, 8'hFF, 0, 8'(8'h30 + k), 2'd3, 1'b0, acc);
         if (acc) k++;
      end
      check("bp_accepted", k, FD);
      for (int i = 0; i < 40 && (k < 6 || exp_q.size() > 0); i++) begin
         step(k < 6, OP_GET, 32'(k % 8) << 3, 8'hFF, 0, 8'(8'h30 + k), 2'd3, 1'b1, acc);
         if (acc) k++;
      end
      check("bp_total", k, 6);
      check("bp_drained", exp_q.size(), 0);

      // Get to word 1024 (address bit above the BRAM range)
      send(OP_GET, 32'h2000, 8'hFF, 64'h0, 8'h55);
      drain();
`ifdef TL_ADAPTER_BRAM_PIPE_ERR_EN
      check("oob_denied", last_denied, 1);
`else
      check("oob_denied", last_denied, 0);
`endif

      // Randomized traffic over words 0..7 with random backpressure
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 2))
            0:       op = OP_PF;
            1:       op = OP_PP;
            default: op = OP_GET;
         endcase
         addr = 32'($urandom_range(0, 7)) << 3;
         if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << (13 + $urandom_range(0, 18)));
         step($urandom_range(0, 3) != 0, op, addr,
              (op == OP_PF) ? 8'hFF : 8'($urandom), {$urandom, $urandom},
              8'($urandom), 2'($urandom), $urandom_range(0, 3) != 0, acc);
      end
      drain();

      // Reset with two reads in flight and one buffered
      for (int i = 0; i < 3; i++) step(1'b1, OP_GET, 32'(i) << 3, 8'hFF, 0, 8'(8'h60 + i), 2'd3, 1'b0, acc);
      step(1'b0, 3'h0, 0, 0, 0, 0, 2'd0, 1'b0, acc);
      #2 rst_n = 1'b0;
      #1 check("rst_async_dvalid", d_valid, 0);
      exp_q.delete();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b0, 3'h0, 0, 0, 0, 0, 2'd0, 1'b1, acc);
      send(OP_GET, 32'h10, 8'hFF, 0, 8'h77);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (checks %0d)", n_chk);
      $fatal(1);
   end

endmodule
